alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices per operand; data width W = 4*NIBBLES.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  command request; sampled only in IDLE.
REQ-005 op  input  3  {l, ALUOP[1:0]} applied unchanged to the ALU for every slice.
REQ-006 a_in, b_in  input  W each  operands, captured on accepted start.
REQ-007 cin  input  1  carry into slice 0 for arithmetic commands.
REQ-008 acc  input  1  accumulate select, captured on accepted start (see Configuration).
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle pulse, high in DONE.
REQ-011 result  output  W  registered wide result.
REQ-012 carry, zero, sign  output  1 each  registered wide flags.
REQ-013 alu_a, alu_b  output  4 each  slice operands driven to the 4-bit ALU.
REQ-014 alu_cin, alu_l  output  1 each; alu_op  output  2  ALU control.
REQ-015 alu_r  input  4; alu_cout, alu_zero, alu_sign  input  1 each  ALU slice response, combinational in the same cycle.

Function
REQ-016 FSM states IDLE, RUN, DONE; single slice index idx, 0..NIBBLES-1.
REQ-017 IDLE: start=1 at an edge -> latch op, a_in, b_in, cin, acc; idx<=0; go RUN.
REQ-018 start while busy=1 is ignored; no queueing.
REQ-019 RUN: alu_a = A[4*idx+3:4*idx], alu_b = b_in slice idx, alu_op = op[1:0], alu_l = op[2], all from latched values.
REQ-020 alu_cin: op[2]=0 -> slice 0 uses latched cin, slice k>0 uses registered alu_cout of slice k-1; op[2]=1 -> 0 for every slice.
REQ-021 Each RUN edge: alu_r -> shadow slice idx; alu_cout -> carry chain register; zero accumulator AND= alu_zero; idx++.
REQ-022 RUN edge with idx=NIBBLES-1 -> go DONE; shadow, carry (last alu_cout, forced 0 when op[2]=1), zero (AND of all slices), sign (last alu_sign) copied to result/flag outputs on this edge.
REQ-023 DONE lasts exactly one cycle (done=1), then IDLE; start in DONE ignored.
REQ-024 Latency: start accepted at edge k -> done high in cycle after edge k+NIBBLES; next start accepted no earlier than edge k+NIBBLES+2.
REQ-025 result and flags hold their value from DONE entry until the next DONE entry; never change in IDLE or RUN.
REQ-026 IDLE and DONE: alu_a=alu_b=0, alu_op=00, alu_l=0, alu_cin=0.

Reset
REQ-027 rst_n=0 at any time, including mid-RUN: state IDLE, idx=0, busy=0, done=0, result=0, carry=0, zero=0, sign=0, all latched operands and shadow cleared; command in flight discarded.
REQ-028 Release of rst_n takes effect without glitch on outputs; first start accepted on first edge after release.

Configuration
REQ-029 Macro ALU_SEQ_ACC_EN defined: latched acc=1 makes A = current result register instead of a_in (running accumulator); acc=0 uses a_in.
REQ-030 Macro ALU_SEQ_ACC_EN undefined: acc port present but ignored, A always a_in; no other behavioural difference.

Verification (NIBBLES=4)
REQ-031 rst_n low two cycles after start -> busy=0, done=0, result=0x0000, no done pulse afterwards.
REQ-032 op=010, a_in=0x00FF, b_in=0x0001, cin=0 -> alu_a sequence F,F,0,0; done 5 edges after start; result=0x0100, carry=0, zero=0, sign=0.
REQ-033 op=010, a_in=0xFFFF, b_in=0x0001, cin=0 -> alu_cin sequence 0,1,1,1; result=0x0000, carry=1, zero=1.
REQ-034 op=1xx, cin=1, any operands -> alu_cin=0 every RUN cycle, alu_l=1, carry=0 at done.
REQ-035 start held high continuously -> commands accepted only every NIBBLES+2 cycles; exactly one done pulse per accepted command.
REQ-036 ALU_SEQ_ACC_EN defined: after REQ-032, op=010, acc=1, b_in=0x0001 -> result=0x0101; undefined -> result=a_in+0x0001.

Source files
------------

// File: rtl/alu_seq_if.sv
// Command/result bus of the sequential slice ALU driver: command fields in,
// status and registered wide result/flags out.
interface alu_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         acc;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         sign;

  modport master (
    output start, op, a_in, b_in, cin, acc,
    input  busy, done, result, carry, zero, sign
  );

  modport slave (
    input  start, op, a_in, b_in, cin, acc,
    output busy, done, result, carry, zero, sign
  );
endinterface

// File: rtl/alu_seq.sv
// Runs a W-bit operation through an external 4-bit ALU one slice per cycle.
// Define ALU_SEQ_ACC_EN to let acc=1 take operand A from the result register.
module alu_seq #(
  parameter int NIBBLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic        alu_cin,
  output logic        alu_l,
  output logic [1:0]  alu_op,
  input  logic [3:0]  alu_r,
  input  logic        alu_cout,
  input  logic        alu_zero,
  input  logic        alu_sign
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  // busy is state_q[1] and done is state_q[0]; 2'b01 is never entered.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             cin_q, cin_d;
  logic [W-1:0]     shadow_q, shadow_d;
  logic             chain_q, chain_d;
  logic             zacc_q, zacc_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic [W-1:0]     a_src;

`ifdef ALU_SEQ_ACC_EN
  assign a_src = bus.acc ? result_q : bus.a_in;
`else
  logic unused_acc;
  assign unused_acc = bus.acc;
  assign a_src      = bus.a_in;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    shadow_d = shadow_q;
    chain_d  = chain_q;
    zacc_d   = zacc_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_cin  = 1'b0;
    alu_l    = 1'b0;
    alu_op   = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          idx_d   = '0;
          op_d    = bus.op;
          a_d     = a_src;
          b_d     = bus.b_in;
          cin_d   = bus.cin;
          zacc_d  = 1'b1;
        end
      end
      RUN: begin
        alu_a   = a_q[4*idx_q +: 4];
        alu_b   = b_q[4*idx_q +: 4];
        alu_op  = op_q[1:0];
        alu_l   = op_q[2];
        // Logic ops never carry; arithmetic ripples the previous slice's carry-out.
        alu_cin = op_q[2] ? 1'b0 : ((idx_q == '0) ? cin_q : chain_q);

        shadow_d[4*idx_q +: 4] = alu_r;
        chain_d = alu_cout;
        zacc_d  = zacc_q & alu_zero;
        idx_d   = idx_q + 1'b1;

        if (idx_q == LAST) begin
          state_d  = DONE;
          idx_d    = '0;
          result_d = shadow_d;
          carry_d  = op_q[2] ? 1'b0 : alu_cout;
          zero_d   = zacc_d;
          sign_d   = alu_sign;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      shadow_q <= '0;
      chain_q  <= 1'b0;
      zacc_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      shadow_q <= shadow_d;
      chain_q  <= chain_d;
      zacc_q   <= zacc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
    end
  end

  assign bus.busy   = state_q[1];
  assign bus.done   = state_q[0];
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
  assign bus.sign   = sign_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq: a 4-bit ALU slice model answers the DUT and a
// wide arithmetic reference predicts slice operands, carries, result and flags.
module tb_alu_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.NIBBLES(N)) bus ();

  logic [3:0] alu_a, alu_b, alu_r;
  logic       alu_cin, alu_l, alu_cout, alu_zero, alu_sign;
  logic [1:0] alu_op;

  alu_seq #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_l    (alu_l),
    .alu_op   (alu_op),
    .alu_r    (alu_r),
    .alu_cout (alu_cout),
    .alu_zero (alu_zero),
    .alu_sign (alu_sign)
  );

  // 4-bit ALU slice: arithmetic A+0/A-B/A+B/A-1 with carry-in, logic AND/OR/XOR/NOT.
  logic [4:0] slice_s;
  always_comb begin
    slice_s = '0;
    if (!alu_l) begin
      case (alu_op)
        2'b00:   slice_s = {1'b0, alu_a} + 5'(alu_cin);
        2'b01:   slice_s = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'(alu_cin);
        2'b10:   slice_s = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_cin);
        default: slice_s = {1'b0, alu_a} + 5'h0F + 5'(alu_cin);
      endcase
    end else begin
      case (alu_op)
        2'b00:   slice_s = {1'b0, alu_a & alu_b};
        2'b01:   slice_s = {1'b0, alu_a | alu_b};
        2'b10:   slice_s = {1'b0, alu_a ^ alu_b};
        default: slice_s = {1'b0, ~alu_a};
      endcase
    end
  end
  assign alu_r    = slice_s[3:0];
  assign alu_cout = slice_s[4];
  assign alu_zero = (slice_s[3:0] == 4'h0);
  assign alu_sign = slice_s[3];

  int           n_pass   = 0;
  int           n_checks = 0;
  logic [W-1:0] model_res = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] opnd_b(input logic [2:0] op, input logic [W-1:0] b);
    case (op[1:0])
      2'b00:   return '0;
      2'b01:   return ~b;
      2'b10:   return b;
      default: return '1;
    endcase
  endfunction

  // Wide reference: {carry, result}.
  function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic c);
    if (op[2]) begin
      case (op[1:0])
        2'b00:   return {1'b0, a & b};
        2'b01:   return {1'b0, a | b};
        2'b10:   return {1'b0, a ^ b};
        default: return {1'b0, ~a};
      endcase
    end
    return {1'b0, a} + {1'b0, opnd_b(op, b)} + (W+1)'(c);
  endfunction

  // Carry entering bit 4k of the wide sum.
  function automatic logic carry_in(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic c, input int k);
    logic [W:0] mask, tmp;
    if (op[2]) return 1'b0;
    mask = ((W+1)'(1) << (4*k)) - 1'b1;
    tmp  = ({1'b0, a} & mask) + ({1'b0, opnd_b(op, b)} & mask) + (W+1)'(c);
    return tmp[4*k];
  endfunction

  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic ac);
    logic [W-1:0] a_eff;
    logic [W:0]   exp;
    int           guard;
    guard = 0;
    while (bus.busy && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("idle_wait", 32'(bus.busy), 0);
    check("idle_alu", 32'({alu_a, alu_b, alu_cin, alu_l, alu_op}), 0);
    a_eff = a;
`ifdef ALU_SEQ_ACC_EN
    if (ac) a_eff = model_res;
`endif
    exp = ref_op(op, a_eff, b, c);
    bus.start = 1'b1; bus.op = op; bus.a_in = a; bus.b_in = b; bus.cin = c; bus.acc = ac;
    @(posedge clk); #1;
    // Scramble inputs so only latched values can produce the right answer.
    bus.start = 1'b0; bus.op = 3'($urandom); bus.a_in = W'($urandom); bus.b_in = W'($urandom);
    bus.cin = 1'($urandom); bus.acc = 1'($urandom);
    check("accept", 32'(bus.busy), 1);
    for (int k = 0; k < N; k++) begin
      check("alu_a", 32'(alu_a), 32'(a_eff[4*k +: 4]));
      check("alu_b", 32'(alu_b), 32'(b[4*k +: 4]));
      check("alu_cin", 32'(alu_cin), 32'(carry_in(op, a_eff, b, c, k)));
      check("alu_ctl", 32'({alu_l, alu_op}), 32'(op));
      check("run_hold", 32'({bus.result, bus.done}), 32'({model_res, 1'b0}));
      @(posedge clk); #1;
    end
    check("done", 32'({bus.busy, bus.done}), 32'b11);
    check("result", 32'(bus.result), 32'(exp[W-1:0]));
    check("flags", 32'({bus.carry, bus.zero, bus.sign}),
          32'({exp[W], exp[W-1:0] == '0, exp[W-1]}));
    check("done_alu", 32'({alu_a, alu_b, alu_cin, alu_l, alu_op}), 0);
    model_res = exp[W-1:0];
    @(posedge clk); #1;
    check("done_pulse", 32'({bus.busy, bus.done}), 0);
    check("idle_hold", 32'(bus.result), 32'(model_res));
  endtask

  int done_cnt;

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.a_in = '0; bus.b_in = '0; bus.cin = 1'b0; bus.acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'({bus.busy, bus.done, bus.result, bus.carry, bus.zero, bus.sign}), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_alu", 32'({alu_a, alu_b, alu_cin, alu_l, alu_op}), 0);

    run_cmd(3'b010, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    check("add_ff_result", 32'(bus.result), 32'h0100);
    check("add_ff_flags", 32'({bus.carry, bus.zero, bus.sign}), 0);

    run_cmd(3'b010, 16'h1234, 16'h0001, 1'b0, 1'b1);
`ifdef ALU_SEQ_ACC_EN
    check("acc_result", 32'(bus.result), 32'h0101);
`else
    check("acc_result", 32'(bus.result), 32'h1235);
`endif

    run_cmd(3'b010, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("wrap_result", 32'(bus.result), 32'h0000);
    check("wrap_cz", 32'({bus.carry, bus.zero}), 32'b11);

    for (int i = 0; i < 4; i++) begin
      run_cmd({1'b1, 2'(i)}, W'($urandom), W'($urandom), 1'b1, 1'b0);
      check("logic_carry", 32'(bus.carry), 0);
    end

    for (int i = 0; i < 30; i++)
      run_cmd(3'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

    // start held high: one accept every N+2 cycles.
    bus.start = 1'b1; bus.op = 3'b001; bus.a_in = 16'h8000; bus.b_in = 16'h0001;
    bus.cin = 1'b1; bus.acc = 1'b0;
    done_cnt = 0;
    for (int cyc = 1; cyc <= 3*(N+2); cyc++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        check("held_done_pos", 32'(cyc), 32'(N + 1 + done_cnt*(N+2)));
        done_cnt++;
      end
    end
    bus.start = 1'b0;
    check("held_done_cnt", 32'(done_cnt), 3);
    check("held_result", 32'({bus.result, bus.carry}), 32'({16'h7FFF, 1'b1}));
    model_res = 16'h7FFF;

    // Reset two cycles into a command.
    bus.start = 1'b1; bus.op = 3'b010; bus.a_in = 16'h5555; bus.b_in = 16'h1111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_rst", 32'({bus.busy, bus.done, bus.result, bus.carry, bus.zero, bus.sign}), 0);
    model_res = '0;
    @(negedge clk) rst_n = 1'b1;
    done_cnt = 0;
    for (int cyc = 0; cyc < N + 3; cyc++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    check("no_done_after_rst", 32'(done_cnt), 0);

    // First edge after release must accept a pending start.
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run_cmd(3'b010, W'($urandom), W'($urandom), 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
